// File: rtl/apb_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_bus_arbiter_if
// Brief    : Requester-side and APB-side signal bundle of the two-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic              err;
    logic [DATA_W-1:0] rdata;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    // Arbiter view: drives completions and the APB request phase.
    modport master (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        output done0, done1, err, rdata,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    // Environment view: requesters plus the APB slave.
    modport slave (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        input  done0, done1, err, rdata,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface
`default_nettype wire

// File: rtl/apb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_bus_arbiter
// Brief    : Round-robin two-requester APB master with wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_bus_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    apb_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // Value of the wait counter at the edge that must abort the transfer.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_wait_cnt;
    logic              r_rr_ptr;
    logic              r_owner;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant_any;
    logic              w_winner;

    // A requester whose done pulse is showing is not eligible this cycle.
    always_comb begin
        w_elig0     = bus.req0 && !r_done0;
        w_elig1     = bus.req1 && !r_done1;
        w_grant_any = w_elig0 || w_elig1;
        if (w_elig0 && w_elig1) begin
            w_winner = ~r_rr_ptr;
        end else begin
            w_winner = w_elig1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_rr_ptr   <= 1'b1;
            r_owner    <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rdata    <= '0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    if (w_grant_any) begin
                        r_state    <= S_SETUP;
                        r_psel     <= 1'b1;
                        r_owner    <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_wait_cnt <= 8'd0;
                        r_pwrite   <= w_winner ? bus.wr1    : bus.wr0;
                        r_paddr    <= w_winner ? bus.addr1  : bus.addr0;
                        r_pwdata   <= w_winner ? bus.wdata1 : bus.wdata0;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_psel    <= 1'b1;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (bus.pready) begin
                        r_state    <= S_IDLE;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_wait_cnt <= 8'd0;
                        r_done0    <= !r_owner;
                        r_done1    <= r_owner;
                        if (!r_pwrite) begin
                            r_rdata <= bus.prdata;
                        end
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_state    <= S_IDLE;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_wait_cnt <= 8'd0;
                        r_done0    <= !r_owner;
                        r_done1    <= r_owner;
                        r_err      <= 1'b1;
                        r_rdata    <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
    assign bus.pwrite  = r_pwrite;
    assign bus.paddr   = r_paddr;
    assign bus.pwdata  = r_pwdata;
    assign bus.rdata   = r_rdata;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;
    assign bus.err     = r_err;

    a_penable_needs_psel : assert property (@(posedge clk) disable iff (!rst)
        r_penable |-> r_psel);
    a_single_done : assert property (@(posedge clk) disable iff (!rst)
        !(r_done0 && r_done1));

endmodule
`default_nettype wire

// File: tb/tb_apb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_bus_arbiter
// Brief    : Scoreboard bench for the two-requester APB arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_bus_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic              id;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];
    logic [DATA_W-1:0] exp_rdata;

    apb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (bus.done0 || bus.done1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'({bus.done1, bus.done0}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_requester", 32'({bus.done1, bus.done0}), e.id ? 32'd2 : 32'd1);
                check("done_err", 32'(bus.err), 32'(e.err));
                check("done_rdata", 32'(bus.rdata), 32'(e.rdata));
            end
        end
    end

    task automatic drive_req(input bit id, input bit r, input bit w,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (id) begin
            bus.req1 = r; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // One transfer; waits >= TIMEOUT means the slave never answers.
    task automatic xfer(input bit id, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int waits,
                        input logic [DATA_W-1:0] rd);
        exp_t e;
        int   n;
        bit   to;
        int   n_acc;
        to    = (waits >= TIMEOUT);
        n_acc = to ? TIMEOUT : waits + 1;
        drive_req(id, 1'b1, wr, a, d);
        bus.pready = 1'b0;
        bus.prdata = rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.psel && n < 10);
        check("setup_psel", 32'(bus.psel), 32'd1);
        check("setup_penable", 32'(bus.penable), 32'd0);
        check("setup_paddr", 32'(bus.paddr), 32'(a));
        check("setup_pwrite", 32'(bus.pwrite), 32'(wr));
        if (wr) check("setup_pwdata", 32'(bus.pwdata), 32'(d));
        e.id    = id;
        e.err   = to;
        e.rdata = to ? '0 : (wr ? exp_rdata : rd);
        exp_rdata = e.rdata;
        exp_q.push_back(e);
        drive_req(id, 1'b0, ~wr, ~a, ~d);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            check("access_phase", 32'({bus.psel, bus.penable}), 32'd3);
            check("access_paddr", 32'(bus.paddr), 32'(a));
            check("access_pwrite", 32'(bus.pwrite), 32'(wr));
            if (!to && i == n_acc - 1) bus.pready = 1'b1;
        end
        @(negedge clk);
        check("done_seen", 32'(id ? bus.done1 : bus.done0), 32'd1);
        check("done_bus_idle", 32'({bus.psel, bus.penable}), 32'd0);
        bus.pready = 1'b0;
        @(negedge clk);
        check("done_single_pulse", 32'({bus.done0, bus.done1}), 32'd0);
    endtask

    // Both requesters held for n writes; grants must alternate from 'first'.
    task automatic rr_run(input int n, input bit first,
                          input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        exp_t e;
        int   got;
        int   gi;
        drive_req(1'b0, 1'b1, 1'b1, a0, 16'h1111);
        drive_req(1'b1, 1'b1, 1'b1, a1, 16'h2222);
        bus.pready = 1'b1;
        for (int k = 0; k < n; k++) begin
            e.id    = first ^ k[0];
            e.err   = 1'b0;
            e.rdata = exp_rdata;
            exp_q.push_back(e);
        end
        got = 0;
        gi  = 0;
        for (int c = 0; c < n * 6 + 10 && got < n; c++) begin
            @(negedge clk);
            if (bus.psel && !bus.penable) begin
                check("rr_grant_order", 32'(bus.paddr), 32'((first ^ gi[0]) ? a1 : a0));
                gi++;
            end
            if (bus.done0 || bus.done1) got++;
        end
        drive_req(1'b0, 1'b0, 1'b0, a0, 16'h0);
        drive_req(1'b1, 1'b0, 1'b0, a1, 16'h0);
        bus.pready = 1'b0;
        check("rr_done_count", 32'(got), 32'(n));
        check("rr_grant_count", 32'(gi), 32'(n));
        @(negedge clk);
        @(negedge clk);
        check("rr_no_extra_grant", 32'(bus.psel), 32'd0);
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        exp_rdata = '0;
        rst = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        bus.prdata = '0;
        bus.pready = 1'b0;

        @(negedge clk);
        check("rst_psel", 32'(bus.psel), 32'd0);
        check("rst_penable", 32'(bus.penable), 32'd0);
        check("rst_pwrite", 32'(bus.pwrite), 32'd0);
        check("rst_paddr", 32'(bus.paddr), 32'd0);
        check("rst_pwdata", 32'(bus.pwdata), 32'd0);
        check("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        xfer(1'b0, 1'b1, 8'h12, 16'hBEEF, 0, 16'h0000);
        xfer(1'b1, 1'b0, 8'h34, 16'h0000, 3, 16'h5A5A);
        rr_run(4, 1'b0, 8'h40, 8'h41);
        xfer(1'b1, 1'b0, 8'h77, 16'h0000, TIMEOUT, 16'hDEAD);
        xfer(1'b0, 1'b0, 8'h56, 16'h0000, 1, 16'h1357);

        // Asynchronous reset in the middle of an ACCESS phase.
        drive_req(1'b0, 1'b1, 1'b0, 8'h22, 16'h0000);
        bus.prdata = 16'h1234;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.psel && bus.penable) && n < 10);
        check("pre_reset_access", 32'({bus.psel, bus.penable}), 32'd3);
        drive_req(1'b0, 1'b0, 1'b0, 8'h22, 16'h0000);
        #2 rst = 1'b0;
        #1;
        check("async_rst_bus", 32'({bus.psel, bus.penable}), 32'd0);
        check("async_rst_done", 32'({bus.done0, bus.done1}), 32'd0);
        check("async_rst_rdata", 32'(bus.rdata), 32'd0);
        exp_q.delete();
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rr_run(2, 1'b0, 8'h60, 8'h61);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
